// File: rtl/sc_level_scheduler_if.sv
// Button/comparator inputs and game-status outputs of the RoadFighter level scheduler.
// The scheduler uses the slave modport; whatever drives the buttons uses master.
interface sc_level_scheduler_if #(
  parameter int LEVEL_WIDTH = 8
);
  logic                   SC_LEVELSCHED_START_InLow;
  logic                   SC_LEVELSCHED_COLLISION_InHigh;
  logic                   SC_LEVELSCHED_LOAD_Out;
  logic                   SC_LEVELSCHED_CLEAR_Out;
  logic [1:0]             SC_LEVELSCHED_MUXSEL_Out;
  logic [LEVEL_WIDTH-1:0] SC_LEVELSCHED_LEVEL_Out;
  logic [1:0]             SC_LEVELSCHED_LIVES_Out;
  logic [2:0]             SC_LEVELSCHED_STATE_Out;
  logic                   SC_LEVELSCHED_GAMEOVER_Out;
  logic                   SC_LEVELSCHED_WIN_Out;

  modport master (
    output SC_LEVELSCHED_START_InLow, SC_LEVELSCHED_COLLISION_InHigh,
    input  SC_LEVELSCHED_LOAD_Out, SC_LEVELSCHED_CLEAR_Out, SC_LEVELSCHED_MUXSEL_Out,
           SC_LEVELSCHED_LEVEL_Out, SC_LEVELSCHED_LIVES_Out, SC_LEVELSCHED_STATE_Out,
           SC_LEVELSCHED_GAMEOVER_Out, SC_LEVELSCHED_WIN_Out
  );

  modport slave (
    input  SC_LEVELSCHED_START_InLow, SC_LEVELSCHED_COLLISION_InHigh,
    output SC_LEVELSCHED_LOAD_Out, SC_LEVELSCHED_CLEAR_Out, SC_LEVELSCHED_MUXSEL_Out,
           SC_LEVELSCHED_LEVEL_Out, SC_LEVELSCHED_LIVES_Out, SC_LEVELSCHED_STATE_Out,
           SC_LEVELSCHED_GAMEOVER_Out, SC_LEVELSCHED_WIN_Out
  );
endinterface

// File: rtl/sc_level_scheduler.sv
// RoadFighter game-flow controller: start/clear/run sequencing, periodic LOAD strobes,
// level and speed-tier progression, crash timing and lives bookkeeping.
module sc_level_scheduler #(
  parameter int TIMER_WIDTH     = 25,
  parameter int TICK_L1         = 17500000,
  parameter int TICK_L2         = 15000000,
  parameter int TICK_L3         = 12500000,
  parameter int LEVEL_WIDTH     = 8,
  parameter int LV_T1_MAX       = 10,
  parameter int LV_T2_MAX       = 32,
  parameter int LV_MAX          = 59,
  parameter int LOADS_PER_LEVEL = 16,
  parameter int CRASH_CYCLES    = 25000000,
  parameter int LIVES_INIT      = 3
) (
  input  logic SC_LEVELSCHED_CLOCK_50,
  input  logic SC_LEVELSCHED_RESET_InLow,
  sc_level_scheduler_if.slave bus
);

  localparam int LC_W = $clog2(LOADS_PER_LEVEL + 1);
  localparam int CC_W = $clog2(CRASH_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_CRASH = 3'd3,
    S_LOSE  = 3'd4,
    S_WIN   = 3'd5
  } state_t;

  state_t                 state, state_nxt;
  logic [TIMER_WIDTH-1:0] timer;
  logic [LC_W-1:0]        load_cnt;
  logic [CC_W-1:0]        crash_cnt;
  logic [LEVEL_WIDTH-1:0] level;
  logic [1:0]             lives;
  logic [1:0]             muxsel;
  logic                   load_r, clear_r, gameover_r, win_r;
  logic                   start_h, start_armed;

  logic start_evt, tick_end, level_end, crash_end, at_max;
  logic fire_load, hit;

  function automatic logic [1:0] tier_of(input logic [LEVEL_WIDTH-1:0] lv);
    if (lv <= LEVEL_WIDTH'(LV_T1_MAX))      return 2'd0;
    else if (lv <= LEVEL_WIDTH'(LV_T2_MAX)) return 2'd1;
    else                                    return 2'd2;
  endfunction

  function automatic logic [TIMER_WIDTH-1:0] period_last(input logic [1:0] tier);
    case (tier)
      2'd0:    return TIMER_WIDTH'(TICK_L1 - 1);
      2'd1:    return TIMER_WIDTH'(TICK_L2 - 1);
      default: return TIMER_WIDTH'(TICK_L3 - 1);
    endcase
  endfunction

  // A press only counts once the button has been seen released after reset,
  // so a button held low through reset release never starts a game.
  assign start_evt = start_armed & start_h & ~bus.SC_LEVELSCHED_START_InLow;
  assign tick_end  = (timer == period_last(muxsel));
  assign level_end = (load_cnt == LC_W'(LOADS_PER_LEVEL - 1));
  assign crash_end = (crash_cnt == CC_W'(CRASH_CYCLES - 1));
  assign at_max    = (level == LEVEL_WIDTH'(LV_MAX));

  always_ff @(posedge SC_LEVELSCHED_CLOCK_50 or negedge SC_LEVELSCHED_RESET_InLow) begin
    if (!SC_LEVELSCHED_RESET_InLow) state <= S_IDLE;
    else                            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fire_load = 1'b0;
    hit       = 1'b0;
    case (state)
      S_IDLE:  if (start_evt) state_nxt = S_CLEAR;
      S_CLEAR: state_nxt = S_RUN;
      S_RUN: begin
        // Collision wins over a coinciding terminal count.
        if (bus.SC_LEVELSCHED_COLLISION_InHigh) begin
          hit       = 1'b1;
          state_nxt = (lives <= 2'd1) ? S_LOSE : S_CRASH;
        end else if (tick_end) begin
          fire_load = 1'b1;
          if (level_end && at_max) state_nxt = S_WIN;
        end
      end
      S_CRASH: if (crash_end) state_nxt = S_CLEAR;
      S_LOSE, S_WIN: if (start_evt) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge SC_LEVELSCHED_CLOCK_50 or negedge SC_LEVELSCHED_RESET_InLow) begin
    if (!SC_LEVELSCHED_RESET_InLow) begin
      timer       <= '0;
      load_cnt    <= '0;
      crash_cnt   <= '0;
      level       <= LEVEL_WIDTH'(1);
      lives       <= 2'(LIVES_INIT);
      muxsel      <= 2'd0;
      load_r      <= 1'b0;
      clear_r     <= 1'b0;
      gameover_r  <= 1'b0;
      win_r       <= 1'b0;
      start_h     <= 1'b1;
      start_armed <= 1'b0;
    end else begin
      start_h     <= bus.SC_LEVELSCHED_START_InLow;
      start_armed <= start_armed | bus.SC_LEVELSCHED_START_InLow;
      load_r      <= fire_load;
      clear_r     <= (state_nxt == S_CLEAR);
      gameover_r  <= (state_nxt == S_LOSE) || (state_nxt == S_WIN);
      win_r       <= (state_nxt == S_WIN);
      case (state)
        S_IDLE: begin
          if (start_evt) begin
            level  <= LEVEL_WIDTH'(1);
            lives  <= 2'(LIVES_INIT);
            muxsel <= tier_of(LEVEL_WIDTH'(1));
          end
        end
        S_CLEAR: begin
          timer     <= '0;
          load_cnt  <= '0;
          crash_cnt <= '0;
        end
        S_RUN: begin
          if (hit) begin
            if (lives != 2'd0) lives <= lives - 2'd1;
            timer     <= '0;
            load_cnt  <= '0;
            crash_cnt <= '0;
          end else if (tick_end) begin
            timer <= '0;
            if (level_end) begin
              load_cnt <= '0;
              if (!at_max) begin
                level  <= level + LEVEL_WIDTH'(1);
                muxsel <= tier_of(level + LEVEL_WIDTH'(1));
              end
            end else begin
              load_cnt <= load_cnt + LC_W'(1);
            end
          end else begin
            timer <= timer + TIMER_WIDTH'(1);
          end
        end
        S_CRASH: begin
          timer     <= '0;
          load_cnt  <= '0;
          crash_cnt <= crash_end ? '0 : crash_cnt + CC_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.SC_LEVELSCHED_LOAD_Out     = load_r;
  assign bus.SC_LEVELSCHED_CLEAR_Out    = clear_r;
  assign bus.SC_LEVELSCHED_MUXSEL_Out   = muxsel;
  assign bus.SC_LEVELSCHED_LEVEL_Out    = level;
  assign bus.SC_LEVELSCHED_LIVES_Out    = lives;
  assign bus.SC_LEVELSCHED_STATE_Out    = state;
  assign bus.SC_LEVELSCHED_GAMEOVER_Out = gameover_r;
  assign bus.SC_LEVELSCHED_WIN_Out      = win_r;

endmodule

// File: tb/tb_sc_level_scheduler.sv
// Directed bench for sc_level_scheduler with small timing parameters.
module tb_sc_level_scheduler;
  localparam int LW = 8;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   n;

  sc_level_scheduler_if #(.LEVEL_WIDTH(LW)) bus ();

  sc_level_scheduler #(
    .TIMER_WIDTH(4), .TICK_L1(4), .TICK_L2(3), .TICK_L3(2),
    .LEVEL_WIDTH(LW), .LV_T1_MAX(2), .LV_T2_MAX(3), .LV_MAX(4),
    .LOADS_PER_LEVEL(2), .CRASH_CYCLES(5), .LIVES_INIT(2)
  ) dut (
    .SC_LEVELSCHED_CLOCK_50(clk),
    .SC_LEVELSCHED_RESET_InLow(rst_n),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Cycles until the next LOAD strobe, bounded at 40.
  task automatic wait_load(output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (bus.SC_LEVELSCHED_LOAD_Out !== 1'b1 && cycles < 40);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.SC_LEVELSCHED_START_InLow      = 1'b1;
    bus.SC_LEVELSCHED_COLLISION_InHigh = 1'b0;
    tick();
    check("rst_state",    32'(bus.SC_LEVELSCHED_STATE_Out), 0);
    check("rst_level",    32'(bus.SC_LEVELSCHED_LEVEL_Out), 1);
    check("rst_lives",    32'(bus.SC_LEVELSCHED_LIVES_Out), 2);
    check("rst_muxsel",   32'(bus.SC_LEVELSCHED_MUXSEL_Out), 0);
    check("rst_load",     32'(bus.SC_LEVELSCHED_LOAD_Out), 0);
    check("rst_clear",    32'(bus.SC_LEVELSCHED_CLEAR_Out), 0);
    check("rst_gameover", 32'(bus.SC_LEVELSCHED_GAMEOVER_Out), 0);
    check("rst_win",      32'(bus.SC_LEVELSCHED_WIN_Out), 0);
    rst_n = 1'b1;
    tick();
    tick();

    // Full game to WIN with no collisions.
    bus.SC_LEVELSCHED_START_InLow = 1'b0;
    tick();
    check("a_clear_state", 32'(bus.SC_LEVELSCHED_STATE_Out), 1);
    check("a_clear_pulse", 32'(bus.SC_LEVELSCHED_CLEAR_Out), 1);
    bus.SC_LEVELSCHED_START_InLow = 1'b1;
    tick();
    check("a_run_state", 32'(bus.SC_LEVELSCHED_STATE_Out), 2);
    check("a_clear_end", 32'(bus.SC_LEVELSCHED_CLEAR_Out), 0);
    wait_load(n); check("a_l1_first", 32'(n), 4);
    tick();
    check("a_load_1cyc", 32'(bus.SC_LEVELSCHED_LOAD_Out), 0);
    wait_load(n); check("a_l1_second", 32'(n + 1), 4);
    check("a_lvl2", 32'(bus.SC_LEVELSCHED_LEVEL_Out), 2);
    check("a_mux_l2", 32'(bus.SC_LEVELSCHED_MUXSEL_Out), 0);
    wait_load(n); check("a_l2_first", 32'(n), 4);
    wait_load(n); check("a_l2_second", 32'(n), 4);
    check("a_lvl3", 32'(bus.SC_LEVELSCHED_LEVEL_Out), 3);
    check("a_mux_l3", 32'(bus.SC_LEVELSCHED_MUXSEL_Out), 1);
    wait_load(n); check("a_l3_first", 32'(n), 3);
    wait_load(n); check("a_l3_second", 32'(n), 3);
    check("a_lvl4", 32'(bus.SC_LEVELSCHED_LEVEL_Out), 4);
    check("a_mux_l4", 32'(bus.SC_LEVELSCHED_MUXSEL_Out), 2);
    wait_load(n); check("a_l4_first", 32'(n), 2);
    check("a_l4_still_run", 32'(bus.SC_LEVELSCHED_STATE_Out), 2);
    wait_load(n); check("a_l4_second", 32'(n), 2);
    check("a_win_state", 32'(bus.SC_LEVELSCHED_STATE_Out), 5);
    check("a_win_gameover", 32'(bus.SC_LEVELSCHED_GAMEOVER_Out), 1);
    check("a_win_flag", 32'(bus.SC_LEVELSCHED_WIN_Out), 1);
    check("a_win_level", 32'(bus.SC_LEVELSCHED_LEVEL_Out), 4);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.SC_LEVELSCHED_LOAD_Out === 1'b1) n++;
    end
    check("a_win_noload", 32'(n), 0);
    check("a_win_hold", 32'(bus.SC_LEVELSCHED_STATE_Out), 5);

    // WIN -> IDLE -> new game, then collision on a terminal count at level 2.
    bus.SC_LEVELSCHED_START_InLow = 1'b0;
    tick();
    check("b_idle", 32'(bus.SC_LEVELSCHED_STATE_Out), 0);
    check("b_idle_go", 32'(bus.SC_LEVELSCHED_GAMEOVER_Out), 0);
    check("b_idle_win", 32'(bus.SC_LEVELSCHED_WIN_Out), 0);
    bus.SC_LEVELSCHED_START_InLow = 1'b1;
    tick();
    bus.SC_LEVELSCHED_START_InLow = 1'b0;
    tick();
    check("b_clear", 32'(bus.SC_LEVELSCHED_STATE_Out), 1);
    check("b_level1", 32'(bus.SC_LEVELSCHED_LEVEL_Out), 1);
    check("b_lives2", 32'(bus.SC_LEVELSCHED_LIVES_Out), 2);
    check("b_mux0", 32'(bus.SC_LEVELSCHED_MUXSEL_Out), 0);
    bus.SC_LEVELSCHED_START_InLow = 1'b1;
    tick();
    wait_load(n); check("b_load1", 32'(n), 4);
    wait_load(n); check("b_load2", 32'(n), 4);
    check("b_lvl2", 32'(bus.SC_LEVELSCHED_LEVEL_Out), 2);
    tick(); tick(); tick();
    bus.SC_LEVELSCHED_COLLISION_InHigh = 1'b1;
    tick();
    bus.SC_LEVELSCHED_COLLISION_InHigh = 1'b0;
    check("b_hit_noload", 32'(bus.SC_LEVELSCHED_LOAD_Out), 0);
    check("b_hit_lives", 32'(bus.SC_LEVELSCHED_LIVES_Out), 1);
    check("b_hit_crash", 32'(bus.SC_LEVELSCHED_STATE_Out), 3);
    n = 0;
    while (bus.SC_LEVELSCHED_STATE_Out === 3'd3 && n < 20) begin
      n++;
      tick();
    end
    check("b_crash_len", 32'(n), 5);
    check("b_crash_clear", 32'(bus.SC_LEVELSCHED_STATE_Out), 1);
    check("b_crash_clrpulse", 32'(bus.SC_LEVELSCHED_CLEAR_Out), 1);
    tick();
    check("b_rerun", 32'(bus.SC_LEVELSCHED_STATE_Out), 2);
    check("b_rerun_lvl", 32'(bus.SC_LEVELSCHED_LEVEL_Out), 2);
    wait_load(n); check("b_rerun_load", 32'(n), 4);

    // Second collision -> LOSE, with START held low from RUN onward.
    bus.SC_LEVELSCHED_START_InLow = 1'b0;
    tick();
    check("c_run_ignore_start", 32'(bus.SC_LEVELSCHED_STATE_Out), 2);
    bus.SC_LEVELSCHED_COLLISION_InHigh = 1'b1;
    tick();
    bus.SC_LEVELSCHED_COLLISION_InHigh = 1'b0;
    check("c_lose", 32'(bus.SC_LEVELSCHED_STATE_Out), 4);
    check("c_lose_lives", 32'(bus.SC_LEVELSCHED_LIVES_Out), 0);
    check("c_lose_go", 32'(bus.SC_LEVELSCHED_GAMEOVER_Out), 1);
    check("c_lose_win", 32'(bus.SC_LEVELSCHED_WIN_Out), 0);
    tick(); tick(); tick();
    check("c_lose_held", 32'(bus.SC_LEVELSCHED_STATE_Out), 4);
    bus.SC_LEVELSCHED_START_InLow = 1'b1;
    tick();
    bus.SC_LEVELSCHED_START_InLow = 1'b0;
    tick();
    check("c_idle", 32'(bus.SC_LEVELSCHED_STATE_Out), 0);
    bus.SC_LEVELSCHED_START_InLow = 1'b1;
    tick();
    bus.SC_LEVELSCHED_START_InLow = 1'b0;
    tick();
    check("c_new_clear", 32'(bus.SC_LEVELSCHED_STATE_Out), 1);
    check("c_new_level", 32'(bus.SC_LEVELSCHED_LEVEL_Out), 1);
    check("c_new_lives", 32'(bus.SC_LEVELSCHED_LIVES_Out), 2);

    // Start pulses during RUN and CRASH are ignored.
    bus.SC_LEVELSCHED_START_InLow = 1'b1;
    tick();
    bus.SC_LEVELSCHED_START_InLow = 1'b0;
    tick();
    bus.SC_LEVELSCHED_START_InLow = 1'b1;
    wait_load(n); check("d_run_pulse_load", 32'(n + 1), 4);
    check("d_run_state", 32'(bus.SC_LEVELSCHED_STATE_Out), 2);
    check("d_run_level", 32'(bus.SC_LEVELSCHED_LEVEL_Out), 1);
    bus.SC_LEVELSCHED_COLLISION_InHigh = 1'b1;
    tick();
    bus.SC_LEVELSCHED_COLLISION_InHigh = 1'b0;
    check("d_crash", 32'(bus.SC_LEVELSCHED_STATE_Out), 3);
    check("d_crash_lives", 32'(bus.SC_LEVELSCHED_LIVES_Out), 1);
    bus.SC_LEVELSCHED_START_InLow = 1'b0;
    tick();
    bus.SC_LEVELSCHED_START_InLow = 1'b1;
    tick();
    n = 0;
    while (bus.SC_LEVELSCHED_STATE_Out === 3'd3 && n < 20) begin
      n++;
      tick();
    end
    check("d_crash_rest", 32'(n), 3);
    tick();
    check("d_rerun", 32'(bus.SC_LEVELSCHED_STATE_Out), 2);
    wait_load(n); check("d_rerun_load", 32'(n), 4);

    // Asynchronous reset between edges, START held low across release.
    tick();
    #2;
    rst_n = 1'b0;
    bus.SC_LEVELSCHED_START_InLow = 1'b0;
    #1;
    check("e_ar_state", 32'(bus.SC_LEVELSCHED_STATE_Out), 0);
    check("e_ar_lives", 32'(bus.SC_LEVELSCHED_LIVES_Out), 2);
    check("e_ar_level", 32'(bus.SC_LEVELSCHED_LEVEL_Out), 1);
    check("e_ar_load", 32'(bus.SC_LEVELSCHED_LOAD_Out), 0);
    check("e_ar_mux", 32'(bus.SC_LEVELSCHED_MUXSEL_Out), 0);
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    check("e_held_idle", 32'(bus.SC_LEVELSCHED_STATE_Out), 0);
    bus.SC_LEVELSCHED_START_InLow = 1'b1;
    tick();
    check("e_release_idle", 32'(bus.SC_LEVELSCHED_STATE_Out), 0);
    bus.SC_LEVELSCHED_START_InLow = 1'b0;
    tick();
    check("e_press_clear", 32'(bus.SC_LEVELSCHED_STATE_Out), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sc_level_scheduler.md
Name: sc_level_scheduler

Overview:
Game-flow controller for the RoadFighter datapath. It sequences each run: start, matrix clear, periodic LOAD strobes to the road/car shift registers, and level progression. It also selects the speed tier that drives the datapath mux selects, and handles crash and lives bookkeeping. It sits between the top-level button/comparator inputs and the matrix register bank.

Parameters:
TIMER_WIDTH, 25, width of tick timer; must hold max(TICK_Lx)-1
TICK_L1, 17500000, clocks between LOADs in tier 0 (0.35 s @50 MHz)
TICK_L2, 15000000, clocks between LOADs in tier 1 (0.30 s)
TICK_L3, 12500000, clocks between LOADs in tier 2 (0.25 s)
LEVEL_WIDTH, 8, level counter width
LV_T1_MAX, 10, last level of tier 0
LV_T2_MAX, 32, last level of tier 1
LV_MAX, 59, final level; completing it wins
LOADS_PER_LEVEL, 16, LOAD strobes per level
CRASH_CYCLES, 25000000, clocks spent in CRASH
LIVES_INIT, 3, lives at game start (1..3)

Ports:
SC_LEVELSCHED_CLOCK_50  in  1  system clock, all logic on rising edge
SC_LEVELSCHED_RESET_InLow  in  1  asynchronous active-low reset
SC_LEVELSCHED_START_InLow  in  1  start button, active-low level
SC_LEVELSCHED_COLLISION_InHigh  in  1  comparator hit, sampled each clock
SC_LEVELSCHED_LOAD_Out  out  1  one-cycle shift/load strobe
SC_LEVELSCHED_CLEAR_Out  out  1  one-cycle matrix clear strobe
SC_LEVELSCHED_MUXSEL_Out  out  2  speed tier 0/1/2
SC_LEVELSCHED_LEVEL_Out  out  LEVEL_WIDTH  current level, 1..LV_MAX
SC_LEVELSCHED_LIVES_Out  out  2  remaining lives
SC_LEVELSCHED_STATE_Out  out  3  state code
SC_LEVELSCHED_GAMEOVER_Out  out  1  high in LOSE or WIN
SC_LEVELSCHED_WIN_Out  out  1  high in WIN

Behaviour:
- Clocking/reset: one clock; reset is asynchronous, active-low. All registers clear immediately on reset assertion.
- Reset values: state=IDLE, LEVEL=1, LIVES=LIVES_INIT, MUXSEL=0, LOAD=0, CLEAR=0, GAMEOVER=0, WIN=0, timer=0, load count=0, crash count=0. The start history register resets to 1 (released).
- Start event: a falling edge of START_InLow, i.e. prev=1 and now=0 on a registered sample. A button held low through reset release generates no event.
- States and codes: IDLE=0, CLEAR=1, RUN=2, CRASH=3, LOSE=4, WIN=5. Undefined codes go to IDLE.
- IDLE: on a start event, load LEVEL=1 and LIVES=LIVES_INIT, then go to CLEAR.
- CLEAR: lasts exactly one cycle with CLEAR_Out=1. Timer and load count reset to 0. Next state is RUN.
- RUN, timer: increments each cycle. When timer==period-1, LOAD_Out=1 for the next cycle only and timer returns to 0.
- RUN, period and tier: period is TICK_L1, TICK_L2 or TICK_L3 by tier. MUXSEL is 0 for LEVEL<=LV_T1_MAX, 1 for LEVEL<=LV_T2_MAX, else 2. MUXSEL is registered and updated together with LEVEL.
- RUN, first LOAD: occurs period cycles after entering RUN.
- RUN, level advance: on the LOAD that makes load count reach LOADS_PER_LEVEL, load count returns to 0. If LEVEL==LV_MAX the block goes to WIN (LEVEL is held); otherwise LEVEL increments. The new period applies from the following timer cycle.
- RUN, collision: COLLISION_InHigh=1 has priority over a same-cycle terminal count, so no LOAD fires. LIVES decrements. If LIVES was 1 the block goes to LOSE with LIVES=0; otherwise it goes to CRASH.
- RUN, other inputs: start events are ignored.
- CRASH: LOAD stays 0 and collision is ignored. After exactly CRASH_CYCLES cycles the block goes to CLEAR. LEVEL is kept; load count and timer are reset.
- LOSE/WIN: GAMEOVER=1, and WIN=1 only in WIN. No LOAD or CLEAR. A start event returns to IDLE.
- LIVES never underflows; LEVEL never exceeds LV_MAX.
- Outputs are registered, except STATE_Out, which is the state register directly.

Test Plan:
Use params TICK_L1=4, TICK_L2=3, TICK_L3=2, LOADS_PER_LEVEL=2, LV_T1_MAX=2, LV_T2_MAX=3, LV_MAX=4, CRASH_CYCLES=5, LIVES_INIT=2.
- Start edge in IDLE -> CLEAR_Out=1 for exactly 1 cycle, then STATE=2. LOADs 4 cycles apart, first LOAD 4 cycles after RUN entry. LEVEL 1->2 after 2 LOADs; after 4 LOADs LEVEL=3, MUXSEL=1, spacing 3.
- Continue with no collision -> LEVEL=4, MUXSEL=2, spacing 2. After the 2nd LOAD of level 4: STATE=5, GAMEOVER=1, WIN=1, LEVEL=4, no further LOADs.
- Collision in the same cycle as a terminal count at LEVEL=2 -> no LOAD, LIVES 2->1, STATE=3 for 5 cycles, CLEAR pulse, RUN with LEVEL=2. Next LOAD comes 4 cycles after RUN entry.
- Second collision -> STATE=4, LIVES=0, GAMEOVER=1, WIN=0. Holding START low causes no change; release then press -> IDLE. Next press -> LEVEL=1, LIVES=2.
- Assert RESET_InLow mid-RUN between clock edges -> all outputs reach reset values before the next edge. START held low across reset release -> stays IDLE until a release-then-press.
- Start pulses during RUN and CRASH -> ignored: state, LEVEL and LOAD timing unchanged.
